// File: rtl/act_compress_writer_pkg.sv
// Shared widths, FSM encoding and write payload for the activation compress writer.
package act_compress_writer_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned IF_WIDTH   = 16;
    localparam int unsigned CNT_WIDTH  = 4;
    localparam int unsigned ROW_WIDTH  = 10;

    typedef enum logic [1:0] {
        AW_IDLE    = 2'd0,
        AW_COLLECT = 2'd1,
        AW_WRITE   = 2'd2,
        AW_DONE    = 2'd3
    } aw_state_e;

    // One row as presented to the flag RAM and column stores.
    typedef struct packed {
        logic [IF_WIDTH-1:0][DATA_WIDTH-1:0] data;
        logic [IF_WIDTH-1:0]                 mask;
        logic [CNT_WIDTH:0]                  cnt;
    } row_wr_t;

endpackage

// File: rtl/act_compress_writer_popcount16.sv
// Combinational adder-tree popcount of a 16-bit vector; shared with the reader side.
module popcount16 (
    input  logic [15:0] vec_i,
    output logic [4:0]  cnt_o
);

    logic [1:0] lvl1 [8];
    logic [2:0] lvl2 [4];
    logic [3:0] lvl3 [2];

    // Balanced pairwise reduction, widening by one bit per level.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lvl1[i] = 2'(vec_i[2*i]) + 2'(vec_i[2*i+1]);
        end
        for (int i = 0; i < 4; i++) begin
            lvl2[i] = 3'(lvl1[2*i]) + 3'(lvl1[2*i+1]);
        end
        for (int i = 0; i < 2; i++) begin
            lvl3[i] = 4'(lvl2[2*i]) + 4'(lvl2[2*i+1]);
        end
        cnt_o = 5'(lvl3[0]) + 5'(lvl3[1]);
    end

endmodule

// File: rtl/act_compress_writer.sv
// Packs a dense activation stream into 16-wide rows and writes the nonzero
// bitmask to the flag RAM together with the nonzero values to the column stores.
module act_compress_writer
    import act_compress_writer_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           in_valid,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic                           in_last,
    output logic                           in_ready,
    input  logic                           wr_stall,
    output logic                           wr_req_act_flag,
    output logic [IF_WIDTH-1:0]            wr_data_act_flag,
    output logic [IF_WIDTH-1:0]            wr_req_act,
    output logic [DATA_WIDTH*IF_WIDTH-1:0] wr_data_act,
    output logic [CNT_WIDTH:0]             row_val_num,
    output logic [ROW_WIDTH-1:0]           rows_written,
    output logic                           done
);

    aw_state_e                           state_q, state_d;
    logic [CNT_WIDTH-1:0]                pos_q, pos_d;
    logic [IF_WIDTH-1:0][DATA_WIDTH-1:0] row_q, row_d;
    logic [IF_WIDTH-1:0]                 mask_q, mask_d;
    logic                                last_q, last_d;
    logic [ROW_WIDTH-1:0]                rows_q, rows_d;
    row_wr_t                             out_q, out_d;
    logic                                in_ready_q;
    logic                                done_q;

    logic [IF_WIDTH-1:0][DATA_WIDTH-1:0] ins_row;
    logic [IF_WIDTH-1:0]                 ins_mask;
    logic [CNT_WIDTH:0]                  ins_cnt;
    logic                                strobe;

    // Row and mask as they would look after accepting the current input element.
    always_comb begin
        ins_row         = row_q;
        ins_mask        = mask_q;
        ins_row[pos_q]  = in_data;
        ins_mask[pos_q] = (in_data != '0);
    end

    popcount16 u_popcount (
        .vec_i (ins_mask),
        .cnt_o (ins_cnt)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        row_d   = row_q;
        mask_d  = mask_q;
        last_d  = last_q;
        rows_d  = rows_q;
        out_d   = out_q;

        unique case (state_q)
            AW_IDLE: begin
                if (start) begin
                    state_d = AW_COLLECT;
                    pos_d   = '0;
                    row_d   = '0;
                    mask_d  = '0;
                    last_d  = 1'b0;
                    rows_d  = '0;
                end
            end
            AW_COLLECT: begin
                if (in_valid) begin
                    row_d  = ins_row;
                    mask_d = ins_mask;
                    pos_d  = pos_q + CNT_WIDTH'(1);
                    last_d = in_last;
                    if ((pos_q == CNT_WIDTH'(IF_WIDTH - 1)) || in_last) begin
                        // Unwritten positions are already zero: the row is cleared on every commit.
                        state_d    = AW_WRITE;
                        out_d.data = ins_row;
                        out_d.mask = ins_mask;
                        out_d.cnt  = ins_cnt;
                    end
                end
            end
            AW_WRITE: begin
                if (!wr_stall) begin
                    rows_d  = rows_q + ROW_WIDTH'(1);
                    pos_d   = '0;
                    row_d   = '0;
                    mask_d  = '0;
                    state_d = last_q ? AW_DONE : AW_COLLECT;
                end
            end
            AW_DONE: begin
                state_d = AW_IDLE;
            end
            default: begin
                state_d = AW_IDLE;
            end
        endcase
    end

    // State, datapath and registered control outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= AW_IDLE;
            pos_q      <= '0;
            row_q      <= '0;
            mask_q     <= '0;
            last_q     <= 1'b0;
            rows_q     <= '0;
            out_q      <= '0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pos_q      <= pos_d;
            row_q      <= row_d;
            mask_q     <= mask_d;
            last_q     <= last_d;
            rows_q     <= rows_d;
            out_q      <= out_d;
            in_ready_q <= (state_d == AW_COLLECT);
            done_q     <= (state_d == AW_DONE);
        end
    end

    // Payload is registered; only the strobes are gated by the same-cycle stall.
    assign strobe           = (state_q == AW_WRITE) && !wr_stall;
    assign wr_req_act_flag  = strobe;
    assign wr_req_act       = out_q.mask & {IF_WIDTH{strobe}};
    assign wr_data_act_flag = out_q.mask;
    assign wr_data_act      = out_q.data;
    assign row_val_num      = out_q.cnt;
    assign rows_written     = rows_q;
    assign in_ready         = in_ready_q;
    assign done             = done_q;

endmodule

// File: tb/tb_act_compress_writer.sv
// Directed self-checking bench for act_compress_writer.
module tb_act_compress_writer;

    localparam int unsigned DW = 8;
    localparam int unsigned IW = 16;

    logic            clk;
    logic            reset;
    logic            start;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_last;
    logic            in_ready;
    logic            wr_stall;
    logic            wr_req_act_flag;
    logic [IW-1:0]   wr_data_act_flag;
    logic [IW-1:0]   wr_req_act;
    logic [DW*IW-1:0] wr_data_act;
    logic [4:0]      row_val_num;
    logic [9:0]      rows_written;
    logic            done;

    int checks = 0;
    int errors = 0;

    act_compress_writer dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .wr_stall         (wr_stall),
        .wr_req_act_flag  (wr_req_act_flag),
        .wr_data_act_flag (wr_data_act_flag),
        .wr_req_act       (wr_req_act),
        .wr_data_act      (wr_data_act),
        .row_val_num      (row_val_num),
        .rows_written     (rows_written),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("in_ready_after_start", in_ready, 1);
        check("rows_after_start", rows_written, 0);
    endtask

    task automatic feed(input logic [DW-1:0] v, input logic last, input logic pulse_start);
        check("in_ready_collect", in_ready, 1);
        in_valid = 1'b1;
        in_data  = v;
        in_last  = last;
        start    = pulse_start;
        tick();
        in_valid = 1'b0;
        in_data  = 'x;
        in_last  = 1'b0;
        start    = 1'b0;
    endtask

    task automatic check_write(input string tag, input logic [IW-1:0] m,
                               input logic [DW*IW-1:0] d, input logic [4:0] c);
        check({tag, "_strobe"}, wr_req_act_flag, 1);
        check({tag, "_flag"}, wr_data_act_flag, m);
        check({tag, "_req"}, wr_req_act, m);
        check({tag, "_data"}, wr_data_act, d);
        check({tag, "_cnt"}, row_val_num, c);
        check({tag, "_in_ready"}, in_ready, 0);
    endtask

    // Scenario 1 pattern: column 1 = 5, column 3 = 7, everything else 0.
    task automatic full_row_frame(input string tag);
        do_start();
        for (int i = 0; i < 16; i++) begin
            feed((i == 1) ? 8'd5 : (i == 3) ? 8'd7 : 8'd0, i == 15, 1'b0);
        end
        check_write(tag, 16'h000A, 128'h07000500, 5'd2);
        tick();
        check({tag, "_done"}, done, 1);
        check({tag, "_rows"}, rows_written, 1);
        check({tag, "_strobe_off"}, wr_req_act_flag, 0);
        tick();
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_rows_hold"}, rows_written, 1);
    endtask

    logic [DW-1:0]    v;
    logic [IW-1:0]    exp_mask;
    logic [DW*IW-1:0] exp_data;
    logic [4:0]       exp_cnt;

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        wr_stall = 1'b0;
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_strobe", wr_req_act_flag, 0);
        check("rst_flag", wr_data_act_flag, 0);
        check("rst_req", wr_req_act, 0);
        check("rst_data", wr_data_act, 0);
        check("rst_cnt", row_val_num, 0);
        check("rst_rows", rows_written, 0);
        check("rst_done", done, 0);
        reset = 1'b1;
        tick();
        tick();
        check("idle_in_ready", in_ready, 0);

        // 1: single full row with last on the 16th element
        full_row_frame("s1");

        // 2: two rows, first write stalled three cycles, second row all 0xFF
        do_start();
        for (int i = 0; i < 16; i++) begin
            if (i == 15) wr_stall = 1'b1;
            feed((i == 1) ? 8'd5 : (i == 3) ? 8'd7 : 8'd0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            check("s2_stall_strobe", wr_req_act_flag, 0);
            check("s2_stall_req", wr_req_act, 0);
            check("s2_stall_flag_hold", wr_data_act_flag, 16'h000A);
            check("s2_stall_data_hold", wr_data_act, 128'h07000500);
            check("s2_stall_in_ready", in_ready, 0);
            check("s2_stall_rows", rows_written, 0);
            tick();
        end
        wr_stall = 1'b0;
        #1;
        check_write("s2_row0", 16'h000A, 128'h07000500, 5'd2);
        tick();
        check("s2_rows1", rows_written, 1);
        check("s2_no_done", done, 0);
        for (int i = 0; i < 16; i++) begin
            feed(8'hFF, i == 15, 1'b0);
        end
        check_write("s2_row1", 16'hFFFF, {16{8'hFF}}, 5'd16);
        tick();
        check("s2_done", done, 1);
        check("s2_rows2", rows_written, 2);
        tick();

        // 3: short frame of five elements
        do_start();
        feed(8'd1, 1'b0, 1'b0);
        feed(8'd2, 1'b0, 1'b0);
        feed(8'd3, 1'b0, 1'b0);
        feed(8'd4, 1'b0, 1'b0);
        feed(8'd9, 1'b1, 1'b0);
        check_write("s3", 16'h001F, 128'h0904030201, 5'd5);
        tick();
        check("s3_done", done, 1);
        check("s3_rows", rows_written, 1);
        tick();

        // 4: all-zero row still writes
        do_start();
        for (int i = 0; i < 16; i++) begin
            feed(8'd0, i == 15, 1'b0);
        end
        check_write("s4", 16'h0000, 128'h0, 5'd0);
        tick();
        check("s4_done", done, 1);
        check("s4_rows", rows_written, 1);
        tick();

        // 5: 100 random rows with bubbles and stray start pulses
        do_start();
        for (int r = 0; r < 100; r++) begin
            exp_mask = '0;
            exp_data = '0;
            exp_cnt  = '0;
            for (int i = 0; i < 16; i++) begin
                while ($urandom_range(0, 3) == 0) begin
                    in_data = 'x;
                    tick();
                end
                v = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(1, 255)) : 8'd0;
                exp_data[i*DW +: DW] = v;
                if (v != 8'd0) begin
                    exp_mask[i] = 1'b1;
                    exp_cnt     = exp_cnt + 5'd1;
                end
                feed(v, (r == 99) && (i == 15), i == 7);
            end
            check_write("s5", exp_mask, exp_data, exp_cnt);
            tick();
            check("s5_rows", rows_written, 10'(r + 1));
        end
        check("s5_done", done, 1);
        tick();

        // 6: reset mid-frame, then a clean frame
        do_start();
        for (int i = 0; i < 7; i++) begin
            feed(8'd3, 1'b0, 1'b0);
        end
        reset = 1'b0;
        #1;
        check("s6_rst_in_ready", in_ready, 0);
        check("s6_rst_strobe", wr_req_act_flag, 0);
        check("s6_rst_flag", wr_data_act_flag, 0);
        check("s6_rst_rows", rows_written, 0);
        check("s6_rst_done", done, 0);
        tick();
        reset = 1'b1;
        tick();
        check("s6_idle_in_ready", in_ready, 0);
        check("s6_idle_strobe", wr_req_act_flag, 0);
        full_row_frame("s6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/act_compress_writer.md
Name: act_compress_writer

Overview:
Write-side packer for the activation buffer. It takes a dense stream of activations, one per cycle, and groups them into 16-wide rows. For each row it builds the nonzero bitmask and issues one write to the flag RAM. In the same cycle it issues column-parallel writes of only the nonzero values, so the flag-driven reader can later fetch them. It sits between the previous layer's output/DMA path and the activation flag RAM plus the 16 column stores.

Parameters:
DATA_WIDTH, 8, activation width in bits
IF_WIDTH, 16, activations per row (= number of column stores, = flag width)
CNT_WIDTH, 4, log2(IF_WIDTH); width of the intra-row position counter
ROW_WIDTH, 10, width of the written-row counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse; begins a frame, ignored unless IDLE
in_valid  in  1  in_data is valid
in_data  in  DATA_WIDTH  dense activation, column order 0..IF_WIDTH-1
in_last  in  1  qualifies the final activation of the frame
in_ready  out  1  writer accepts in_data this cycle
wr_stall  in  1  downstream RAM cannot accept a write this cycle
wr_req_act_flag  out  1  flag RAM write strobe
wr_data_act_flag  out  IF_WIDTH  nonzero bitmask; bit i = column i
wr_req_act  out  IF_WIDTH  per-column write strobe (= mask bits)
wr_data_act  out  DATA_WIDTH*IF_WIDTH  column i at bits [i*DATA_WIDTH +: DATA_WIDTH]
row_val_num  out  CNT_WIDTH+1  popcount of the current write's mask
rows_written  out  ROW_WIDTH  rows committed since start
done  out  1  single-cycle pulse after the last row is committed

Behaviour:
- Reset values: all outputs 0; state IDLE; row buffer, mask and counters cleared.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE: in_ready=0. start -> COLLECT; pos=0, rows_written=0, mask=0.
- COLLECT: in_ready=1. A handshake is in_valid&&in_ready.
  - On a handshake: buf[pos]<=in_data; mask[pos]<=(in_data!=0); pos++.
  - If pos==IF_WIDTH-1 or in_last: go to WRITE. Positions not yet written are padded with data 0 and mask 0.
  - Remember in_last as last_row.
- WRITE: in_ready=0. Outputs are registered and held stable while wr_stall=1.
  - wr_req_act_flag=!wr_stall.
  - wr_req_act=mask&{IF_WIDTH{!wr_stall}}.
  - wr_data_act=buf; wr_data_act_flag=mask; row_val_num=popcount(mask).
  - On a non-stalled cycle the row is committed: rows_written++ (wraps modulo 2^ROW_WIDTH); pos=0; mask=0. Then go to DONE if last_row, else COLLECT.
- Latency: the strobe fires in the cycle after the accepting handshake of the 16th or last element. A full row occupies 16 input cycles plus 1 write cycle, so sustained throughput is 16/17.
- All-zero row: the flag write still fires with mask 0, wr_req_act=0, row_val_num=0. Zero rows are never skipped, because the reader counts rows.
- DONE: done=1 for one cycle -> IDLE. rows_written holds until the next start.
- wr_data_act is don't-care for columns whose mask bit is 0. Drive buf, which is 0 for padded positions.
- start outside IDLE is ignored.
- in_last on position 15 behaves like a normal full row followed by DONE.
- Reset asserted mid-frame aborts immediately to IDLE with no partial write.
- in_data holding X while in_valid=0 must not affect state.

Decomposition:
- Shared def_params.vh supplies DATA_WIDTH, IF_WIDTH, ACT_INDEX_WIDTH and the state encodings (AW_IDLE, AW_COLLECT, AW_WRITE, AW_DONE).
- One natural sub-module, popcount16: a combinational adder tree producing a 5-bit count. It is reusable by the reader side for its per-row nonzero count.

Test Plan:
1. Full row. start, then 16 values 0,5,0,7,0,…,0 with in_last on the 16th -> one strobe with wr_data_act_flag=16'h000A, wr_req_act=16'h000A, columns 1/3=5/7, row_val_num=2, rows_written=1, done pulses next cycle.
2. Two rows with wr_stall=1 for 3 cycles during the first write -> outputs held, strobes low for 3 cycles then one strobe, in_ready=0 throughout; the second row (all 8'hFF) gives flag 16'hFFFF, row_val_num=16, rows_written=2.
3. Short frame. 5 values 1,2,3,4,9 with in_last -> flag 16'h001F, positions 5–15 data 0, done pulses.
4. All-zero row. 16 zeros + in_last -> strobe with flag 0, wr_req_act=0, row_val_num=0, rows_written=1.
5. Bubbles and misuse. Random in_valid gaps, start pulsed mid-COLLECT -> ignored; mask matches the golden model over 100 random rows.
6. Reset low after 7 accepted elements -> outputs 0, no strobe, state IDLE; a subsequent start and full row behave as in scenario 1.
